// File: rtl/elink_frame_deser.sv
// elink receive deserializer: rebuilds 76-bit messages from SOP / 10 data / EOP byte frames.
// Optional ELINK_DESER_PAD_CHECK_EN: a nonzero padding nibble in data byte 9 rejects the frame at EOP.
module elink_frame_deser #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_8bit_in,
    input  logic [1:0]  delimiter_in,
    input  logic        byte_valid,
    output logic [75:0] data_rec_out,
    output logic        data_rec_valid,
    output logic        frame_err,
    output logic        busy
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    localparam logic [1:0] D_SOP  = 2'b10;
    localparam logic [1:0] D_DATA = 2'b00;
    localparam logic [1:0] D_EOP  = 2'b01;
    localparam logic [1:0] D_FILL = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_WAIT_EOP} state_t;

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_cnt, w_cnt_nxt;
    logic [TW-1:0] r_to_cnt, w_to_nxt;
    logic [75:0]   r_asm, w_asm_nxt;
    logic [75:0]   r_out, w_out_nxt;
    logic          r_vld, w_vld_nxt;
    logic          r_err, w_err_nxt;
    logic          w_acc;
    logic          w_pad_bad;

    // Filler bytes are not "accepted": they neither advance the FSM nor feed the timeout.
    assign w_acc = byte_valid && (delimiter_in != D_FILL);

`ifdef ELINK_DESER_PAD_CHECK_EN
    logic r_pad_bad, w_pad_nxt;

    always_comb begin
        w_pad_nxt = r_pad_bad;
        if (w_acc && delimiter_in == D_DATA && r_state == S_DATA && r_cnt == 4'd9)
            w_pad_nxt = |data_8bit_in[3:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_pad_bad <= 1'b0;
        else      r_pad_bad <= w_pad_nxt;
    end

    assign w_pad_bad = r_pad_bad;
`else
    assign w_pad_bad = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_to_nxt    = r_to_cnt;
        w_asm_nxt   = r_asm;
        w_out_nxt   = r_out;
        w_vld_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_to_nxt = '0;
                if (w_acc) begin
                    if (delimiter_in == D_SOP) begin
                        w_state_nxt = S_DATA;
                        w_cnt_nxt   = 4'd0;
                        w_asm_nxt   = '0;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            default: begin
                if (w_acc) begin
                    w_to_nxt = '0;
                    case (delimiter_in)
                        D_SOP: begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = S_DATA;
                            w_cnt_nxt   = 4'd0;
                            w_asm_nxt   = '0;
                        end
                        D_EOP: begin
                            w_state_nxt = S_IDLE;
                            if (r_state == S_WAIT_EOP && !w_pad_bad) begin
                                w_out_nxt = r_asm;
                                w_vld_nxt = 1'b1;
                            end else begin
                                w_err_nxt = 1'b1;
                            end
                        end
                        default: begin
                            if (r_state == S_DATA) begin
                                w_cnt_nxt = r_cnt + 4'd1;
                                // Bytes fill MSB-first; the last byte contributes only its high nibble.
                                if (r_cnt == 4'd9) begin
                                    w_asm_nxt   = {r_asm[71:0], data_8bit_in[7:4]};
                                    w_state_nxt = S_WAIT_EOP;
                                end else begin
                                    w_asm_nxt = {r_asm[67:0], data_8bit_in};
                                end
                            end else begin
                                w_err_nxt   = 1'b1;
                                w_state_nxt = S_IDLE;
                            end
                        end
                    endcase
                end else if (TIMEOUT > 0) begin
                    if (r_to_cnt == TO_LAST) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                        w_to_nxt    = '0;
                    end else begin
                        w_to_nxt = r_to_cnt + TW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_to_cnt <= '0;
            r_asm    <= '0;
            r_out    <= '0;
            r_vld    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_to_cnt <= w_to_nxt;
            r_asm    <= w_asm_nxt;
            r_out    <= w_out_nxt;
            r_vld    <= w_vld_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign data_rec_out   = r_out;
    assign data_rec_valid = r_vld;
    assign frame_err      = r_err;
    assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_elink_frame_deser.sv
// Bench for elink_frame_deser: directed vector table, hand sequences, and randomized frames vs a queue-level model.
module tb_elink_frame_deser;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  data_8bit_in = 8'h00;
    logic [1:0]  delimiter_in = 2'b11;
    logic        byte_valid = 1'b0;

    logic [75:0] a_out, t_out;
    logic        a_vld, a_err, a_busy, t_vld, t_err, t_busy;

    elink_frame_deser #(.TIMEOUT(255)) dut_a (
        .clk(clk), .rst(rst), .data_8bit_in(data_8bit_in), .delimiter_in(delimiter_in),
        .byte_valid(byte_valid), .data_rec_out(a_out), .data_rec_valid(a_vld),
        .frame_err(a_err), .busy(a_busy));

    elink_frame_deser #(.TIMEOUT(4)) dut_t (
        .clk(clk), .rst(rst), .data_8bit_in(data_8bit_in), .delimiter_in(delimiter_in),
        .byte_valid(byte_valid), .data_rec_out(t_out), .data_rec_valid(t_vld),
        .frame_err(t_err), .busy(t_busy));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n_err = 0;
    int n_vld = 0;

    localparam logic [75:0] GOOD  = 76'hA1B2C3D4E5F60718293;
    localparam logic [75:0] GOOD2 = 76'h0123456789ABCDEF102;
    logic [7:0] gb[10]  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18, 8'h29, 8'h30};
    logic [7:0] gb2[10] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h10, 8'h20};

    task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] d, input logic [7:0] b);
        byte_valid   = v;
        delimiter_in = d;
        data_8bit_in = b;
        @(posedge clk);
        #1;
        n_err += int'(a_err);
        n_vld += int'(a_vld);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'b11, 8'h00);
    endtask

    // ---------------- reference model: frames as byte lists ----------------
    int          m_to[2] = '{255, 4};
    bit          m_in[2];
    int          m_idle[2];
    int          m_nb[2];
    logic [7:0]  m_b[2][10];
    logic [75:0] m_out[2];
    logic        m_vld[2], m_err[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_in[k] = 0; m_idle[k] = 0; m_nb[k] = 0; m_out[k] = '0;
            m_vld[k] = 0; m_err[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input logic v, input logic [1:0] d, input logic [7:0] b);
        logic acc;
        logic pad_bad;
        logic [75:0] msg;
        acc = v && (d != 2'b11);
        m_vld[k] = 0;
        m_err[k] = 0;
        if (!m_in[k]) begin
            m_idle[k] = 0;
            if (acc) begin
                if (d == 2'b10) begin m_in[k] = 1; m_nb[k] = 0; end
                else m_err[k] = 1;
            end
        end else if (acc) begin
            m_idle[k] = 0;
            if (d == 2'b10) begin
                m_err[k] = 1; m_nb[k] = 0;
            end else if (d == 2'b00) begin
                if (m_nb[k] < 10) begin m_b[k][m_nb[k]] = b; m_nb[k]++; end
                else begin m_err[k] = 1; m_in[k] = 0; end
            end else begin
                m_in[k] = 0;
`ifdef ELINK_DESER_PAD_CHECK_EN
                pad_bad = (m_nb[k] == 10) && (m_b[k][9][3:0] != 4'h0);
`else
                pad_bad = 0;
`endif
                if (m_nb[k] == 10 && !pad_bad) begin
                    msg = '0;
                    for (int i = 0; i < 9; i++) msg = (msg << 8) | 76'(m_b[k][i]);
                    msg = (msg << 4) | 76'(m_b[k][9] >> 4);
                    m_out[k] = msg;
                    m_vld[k] = 1;
                end else m_err[k] = 1;
            end
        end else begin
            m_idle[k]++;
            if (m_idle[k] >= m_to[k]) begin m_err[k] = 1; m_in[k] = 0; m_idle[k] = 0; end
        end
    endtask

    task automatic rstep(input logic v, input logic [1:0] d, input logic [7:0] b);
        byte_valid   = v;
        delimiter_in = d;
        data_8bit_in = b;
        @(posedge clk);
        model_step(0, v, d, b);
        model_step(1, v, d, b);
        #1;
        chk("rnd_a_out", a_out, m_out[0]);
        chk("rnd_a_vld", a_vld, m_vld[0]);
        chk("rnd_a_err", a_err, m_err[0]);
        chk("rnd_a_busy", a_busy, m_in[0]);
        chk("rnd_t_out", t_out, m_out[1]);
        chk("rnd_t_vld", t_vld, m_vld[1]);
        chk("rnd_t_err", t_err, m_err[1]);
        chk("rnd_t_busy", t_busy, m_in[1]);
        chk("rnd_excl", a_vld & a_err, 76'd0);
    endtask

    task automatic rgap(input bit stall);
        int r;
        if (stall) begin
            r = $urandom_range(4, 6);
            for (int i = 0; i < r; i++) rstep(1'b0, 2'b11, 8'($urandom));
        end else begin
            r = $urandom_range(0, 7);
            if (r == 0) rstep(1'b0, 2'b00, 8'($urandom));
            else if (r == 1) rstep(1'b1, 2'b11, 8'($urandom));
            else if (r == 2) begin rstep(1'b0, 2'b10, 8'($urandom)); rstep(1'b1, 2'b11, 8'($urandom)); end
        end
    endtask

    task automatic rframe();
        int kind, n;
        logic [7:0] byt;
        kind = $urandom_range(0, 9);
        if (kind == 0) rstep(1'b1, $urandom_range(0, 1) ? 2'b01 : 2'b00, 8'($urandom));
        n = (kind == 1) ? $urandom_range(0, 9) : (kind == 2) ? 11 : 10;
        rstep(1'b1, 2'b10, 8'($urandom));
        for (int i = 0; i < n; i++) begin
            rgap(kind == 3 && i == 4);
            if (kind == 4 && i == 3) rstep(1'b1, 2'b10, 8'($urandom));
            byt = 8'($urandom);
            if (i == 9 && $urandom_range(0, 3) != 0) byt[3:0] = 4'h0;
            rstep(1'b1, 2'b00, byt);
        end
        rgap(1'b0);
        rstep(1'b1, 2'b01, 8'($urandom));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        v;
        logic [1:0]  d;
        logic [7:0]  b;
        logic        e_vld;
        logic        e_err;
        logic        e_busy;
        logic        c_out;
        logic [75:0] e_out;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [1:0] d, logic [7:0] b, logic ev, logic ee,
                                logic eb, logic co, logic [75:0] eo);
        vec_t r;
        r.v = v; r.d = d; r.b = b; r.e_vld = ev; r.e_err = ee; r.e_busy = eb;
        r.c_out = co; r.e_out = eo;
        return r;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_out", a_out, 76'd0);
        chk("rst_a_flags", {a_vld, a_err, a_busy}, 76'd0);
        chk("rst_t_flags", {t_vld, t_err, t_busy}, 76'd0);
        rst = 1'b1;

        // good frame, short frame, overlength frame
        tbl.push_back(mk(1, 2'b10, 8'h55, 0, 0, 1, 0, '0));
        for (int i = 0; i < 10; i++) tbl.push_back(mk(1, 2'b00, gb[i], 0, 0, 1, 0, '0));
        tbl.push_back(mk(1, 2'b01, 8'hEE, 1, 0, 0, 1, GOOD));
        tbl.push_back(mk(0, 2'b11, 8'h00, 0, 0, 0, 1, GOOD));
        tbl.push_back(mk(1, 2'b10, 8'h00, 0, 0, 1, 0, '0));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(1, 2'b00, 8'h99, 0, 0, 1, 0, '0));
        tbl.push_back(mk(1, 2'b01, 8'h00, 0, 1, 0, 1, GOOD));
        tbl.push_back(mk(0, 2'b11, 8'h00, 0, 0, 0, 1, GOOD));
        tbl.push_back(mk(1, 2'b10, 8'h00, 0, 0, 1, 0, '0));
        for (int i = 0; i < 10; i++) tbl.push_back(mk(1, 2'b00, 8'h77, 0, 0, 1, 0, '0));
        tbl.push_back(mk(1, 2'b00, 8'h77, 0, 1, 0, 1, GOOD));
        tbl.push_back(mk(1, 2'b01, 8'h00, 0, 1, 0, 1, GOOD));
        tbl.push_back(mk(1, 2'b11, 8'h00, 0, 0, 0, 1, GOOD));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].b);
            chk($sformatf("tbl%0d_vld", i), a_vld, tbl[i].e_vld);
            chk($sformatf("tbl%0d_err", i), a_err, tbl[i].e_err);
            chk($sformatf("tbl%0d_busy", i), a_busy, tbl[i].e_busy);
            if (tbl[i].c_out) chk($sformatf("tbl%0d_out", i), a_out, tbl[i].e_out);
        end

        // re-SOP mid-frame then a good frame
        n_err = 0; n_vld = 0;
        drive(1, 2'b10, 8'h00);
        for (int i = 0; i < 4; i++) drive(1, 2'b00, 8'hCC);
        drive(1, 2'b10, 8'h00);
        chk("resop_err", a_err, 1);
        chk("resop_busy", a_busy, 1);
        for (int i = 0; i < 10; i++) drive(1, 2'b00, gb2[i]);
        drive(1, 2'b01, 8'h00);
        chk("resop_vld", a_vld, 1);
        chk("resop_out", a_out, GOOD2);
        idle(1);
        chk("resop_errcnt", n_err, 1);
        chk("resop_vldcnt", n_vld, 1);

        // asynchronous reset mid-frame
        drive(1, 2'b10, 8'h00);
        for (int i = 0; i < 3; i++) drive(1, 2'b00, 8'h42);
        chk("midrst_busy_before", a_busy, 1);
        rst = 1'b0;
        #1;
        chk("midrst_out", a_out, 76'd0);
        chk("midrst_flags", {a_vld, a_err, a_busy}, 76'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // filler bytes and byte_valid gaps inside a frame
        n_err = 0; n_vld = 0;
        drive(1, 2'b10, 8'h00);
        for (int i = 0; i < 10; i++) begin
            drive(1, 2'b00, gb[i]);
            if (i == 4) for (int j = 0; j < 3; j++) drive(1, 2'b11, 8'h5A);
            idle(5);
        end
        drive(1, 2'b01, 8'h00);
        chk("fill_vld", a_vld, 1);
        chk("fill_out", a_out, GOOD);
        idle(1);
        chk("fill_errcnt", n_err, 0);
        chk("fill_vldcnt", n_vld, 1);

        // timeout on the TIMEOUT=4 instance
        rst = 1'b0;
        #2;
        rst = 1'b1;
        drive(1, 2'b10, 8'h00);
        for (int i = 0; i < 3; i++) drive(1, 2'b00, 8'h11);
        idle(3);
        chk("to_err_early", t_err, 0);
        chk("to_busy_early", t_busy, 1);
        idle(1);
        chk("to_err", t_err, 1);
        chk("to_busy", t_busy, 0);
        drive(1, 2'b00, 8'h11);
        chk("to_late_err", t_err, 1);
        idle(1);
        chk("to_clear", t_err, 0);

        // padding nibble in the last data byte
        rst = 1'b0;
        #2;
        rst = 1'b1;
        drive(1, 2'b10, 8'h00);
        for (int i = 0; i < 9; i++) drive(1, 2'b00, gb[i]);
        drive(1, 2'b00, 8'h35);
        drive(1, 2'b01, 8'h00);
`ifdef ELINK_DESER_PAD_CHECK_EN
        chk("pad_err", a_err, 1);
        chk("pad_vld", a_vld, 0);
        chk("pad_out", a_out, 76'd0);
`else
        chk("pad_err", a_err, 0);
        chk("pad_vld", a_vld, 1);
        chk("pad_out", a_out, GOOD);
`endif

        // randomized frames against the model
        rst = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        for (int f = 0; f < 120; f++) rframe();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/elink_frame_deser.md
Name: elink_frame_deser

Overview:
- Receive-side counterpart of the 76-bit message serializer on the elink path.
- Consumes the 8-bit data plus 2-bit delimiter byte stream from the elink, locates start-of-packet (SOP) and end-of-packet (EOP), and reassembles the 76-bit message.
- Hands the message to the SCB / Object Dictionary side with a one-cycle valid strobe.
- Flags malformed frames and times out stalled frames.

Parameters:
- TIMEOUT, 255, idle clock cycles allowed between accepted bytes inside a frame before abort; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- data_8bit_in  input  8  elink payload byte.
- delimiter_in  input  2  byte tag: 2'b11 idle, 2'b10 SOP, 2'b00 data, 2'b01 EOP.
- byte_valid  input  1  data_8bit_in and delimiter_in are sampled when high.
- data_rec_out  output  76  last complete message, bit 75 = MSB of first data byte.
- data_rec_valid  output  1  one-cycle pulse when data_rec_out is updated.
- frame_err  output  1  one-cycle pulse on any framing error or timeout.
- busy  output  1  high while a frame is in progress (state is not IDLE).

Behaviour:
- Reset (rst low, asynchronous): state = IDLE, byte counter = 0, timeout counter = 0, shift/assembly register = 0, data_rec_out = 0, data_rec_valid = 0, frame_err = 0, busy = 0.
- Only cycles with byte_valid = 1 advance the FSM.
- Delimiter 2'b11 with byte_valid = 1 is filler: ignored in every state, does not reset the timeout.
- Frame format: SOP, then 10 data bytes (delimiter 00), then EOP.
  - Data bytes 0..8 map to bits [75:68], [67:60], ..., [11:4].
  - Data byte 9 bits [7:4] map to bits [3:0]; its bits [3:0] are padding.
  - Payload bytes of SOP and EOP are ignored.
- States:
  - IDLE:
    - SOP -> DATA, byte counter = 0, assembly register cleared.
    - 00 or 01 -> frame_err pulse, stay IDLE.
  - DATA:
    - 00 -> store byte at counter position, counter + 1; on the 10th byte (counter = 9) -> WAIT_EOP.
    - SOP -> frame_err pulse, restart: counter = 0, stay DATA.
    - EOP (short frame) -> frame_err pulse, -> IDLE.
  - WAIT_EOP:
    - EOP -> data_rec_out loaded from assembly register, data_rec_valid pulsed, -> IDLE.
    - 00 (overlength) -> frame_err pulse, -> IDLE.
    - SOP -> frame_err pulse, -> DATA with counter = 0.
- Latency: data_rec_out and data_rec_valid update on the clock edge that samples the EOP byte, so they are visible in the following cycle. data_rec_valid is high for exactly one cycle.
- Holding: data_rec_out holds its value until the next good frame. Errored frames never modify it.
- Back-to-back frames are allowed: SOP in the cycle immediately after EOP is accepted with no gap.
- Timeout (TIMEOUT > 0):
  - In DATA or WAIT_EOP, count cycles without an accepted non-filler byte.
  - When the count reaches TIMEOUT: frame_err pulse, -> IDLE.
  - The count is cleared on every accepted 00, 10 or 01 byte and in IDLE.
- frame_err and data_rec_valid are never high in the same cycle.
- Reset asserted mid-frame aborts the frame with no error pulse; data_rec_out returns to 0.

Optional Feature:
- Macro ELINK_DESER_PAD_CHECK_EN.
- Defined: nonzero padding nibble (data byte 9 bits [3:0]) marks the frame bad. The frame still runs to EOP, but at EOP frame_err pulses instead of data_rec_valid, and data_rec_out is unchanged.
- Undefined: the padding nibble is ignored.

Test Plan:
- Good frame: SOP, bytes 8'hA1,8'hB2,8'hC3,8'hD4,8'hE5,8'hF6,8'h07,8'h18,8'h29,8'h30, EOP -> data_rec_out = 76'hA1B2C3D4E5F60718293, data_rec_valid for one cycle after the EOP edge, frame_err = 0.
- Filler tolerance: same frame with 3 idle (11) bytes after byte 4 and byte_valid gaps of 5 cycles -> identical output, no error.
- Short frame: SOP, 6 data bytes, EOP -> frame_err pulse, data_rec_out keeps its previous value, busy = 0.
- Overlength and re-SOP:
  - 11 data bytes -> frame_err on the 11th byte.
  - SOP mid-DATA followed by a good 10-byte frame and EOP -> one frame_err, then a correct data_rec_valid.
- Timeout: TIMEOUT = 4, SOP plus 3 bytes, then byte_valid low for 4 cycles -> frame_err after the 4th idle cycle, state IDLE. A late data byte then gives another frame_err.
- Reset/pad: rst low mid-frame -> all outputs 0 immediately. With ELINK_DESER_PAD_CHECK_EN, last byte 8'h35 -> frame_err at EOP; without the macro -> data_rec_valid, bits [3:0] = 4'h3.
